// File: rtl/key_debounce.sv
// key_debounce
//   Debounces NKEY raw push-button pins. Each pin goes through a two-flop
//   synchronizer and is normalised so that 1 means pressed. A shared
//   prescaler produces a sample tick every CDIV clocks. Each key has its own
//   four-state FSM and stability counter. A key must hold a new level for
//   STABLE_CNT consecutive ticks before that level is accepted. On acceptance
//   the key emits a one-cycle press or release pulse.
//
// Ports
//   clk          system clock
//   n_rst        asynchronous active-low reset
//   key_in       raw key pins, NKEY bits, asynchronous to clk
//   key_level    debounced key state, 1 = pressed
//   key_press    one-cycle pulse when a press is accepted
//   key_release  one-cycle pulse when a release is accepted
module key_debounce #(
  parameter int CDIV       = 50_000,
  parameter int STABLE_CNT = 16,
  parameter int NKEY       = 3,
  parameter int ACTIVE_LOW = 1
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [NKEY-1:0] key_in,
  output logic [NKEY-1:0] key_level,
  output logic [NKEY-1:0] key_press,
  output logic [NKEY-1:0] key_release
);

  localparam int PW = (CDIV > 1) ? $clog2(CDIV) : 1;
  localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT + 1) : 1;
  localparam logic [NKEY-1:0] IDLE_PIN = (ACTIVE_LOW != 0) ? {NKEY{1'b1}} : {NKEY{1'b0}};
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CDIV - 1);
  localparam logic [CW-1:0]   CNT_LAST   = CW'(STABLE_CNT - 1);

  typedef enum logic [1:0] {
    REL     = 2'd0,
    REL_CHK = 2'd1,
    PRS     = 2'd2,
    PRS_CHK = 2'd3
  } state_t;

  logic [NKEY-1:0] sync1_reg;
  logic [NKEY-1:0] sync2_reg;
  logic [NKEY-1:0] s;
  logic [PW-1:0]   presc_reg;
  logic            tick;

  // The synchronizer resets to the idle pin level. A key that is held
  // through reset then looks like a fresh press and goes through a full
  // debounce window.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_reg <= IDLE_PIN;
      sync2_reg <= IDLE_PIN;
    end else begin
      sync1_reg <= key_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign s = (ACTIVE_LOW != 0) ? ~sync2_reg : sync2_reg;

  // Free-running prescaler. When CDIV is 1 it stays at 0, so tick is
  // high on every cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      presc_reg <= '0;
    end else if (presc_reg == PRESC_LAST) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  assign tick = (presc_reg == PRESC_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < NKEY; gi++) begin : g_key
      state_t          state_reg;
      state_t          state_next;
      logic [CW-1:0]   cnt_reg;
      logic [CW-1:0]   cnt_next;
      logic            level_reg;
      logic            level_next;
      logic            press_reg;
      logic            press_next;
      logic            release_reg;
      logic            release_next;

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          state_reg   <= REL;
          cnt_reg     <= '0;
          level_reg   <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          state_reg   <= state_next;
          cnt_reg     <= cnt_next;
          level_reg   <= level_next;
          press_reg   <= press_next;
          release_reg <= release_next;
        end
      end

      always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        case (state_reg)
          REL: begin
            if (s[gi]) begin
              state_next = REL_CHK;
              cnt_next   = '0;
            end
          end
          REL_CHK: begin
            if (!s[gi]) begin
              // Glitch: the level did not hold, so drop the partial count.
              state_next = REL;
              cnt_next   = '0;
            end else if (tick) begin
              if (cnt_reg == CNT_LAST) begin
                state_next = PRS;
                cnt_next   = '0;
                press_next = 1'b1;
              end else begin
                cnt_next = cnt_reg + CW'(1);
              end
            end
          end
          PRS: begin
            if (!s[gi]) begin
              state_next = PRS_CHK;
              cnt_next   = '0;
            end
          end
          PRS_CHK: begin
            if (s[gi]) begin
              state_next = PRS;
              cnt_next   = '0;
            end else if (tick) begin
              if (cnt_reg == CNT_LAST) begin
                state_next   = REL;
                cnt_next     = '0;
                release_next = 1'b1;
              end else begin
                cnt_next = cnt_reg + CW'(1);
              end
            end
          end
          default: begin
            state_next = REL;
            cnt_next   = '0;
          end
        endcase
        // The level is taken from the next state. It therefore updates on
        // the same edge as the press or release pulse.
        level_next = (state_next == PRS) || (state_next == PRS_CHK);
      end

      assign key_level[gi]   = level_reg;
      assign key_press[gi]   = press_reg;
      assign key_release[gi] = release_reg;
    end
  endgenerate

endmodule
